// File: rtl/aes_rx_collector.sv
`default_nettype none
// ============================================================================
// Module      : aes_rx_collector
// Description : Receive-side collector for the AES-GCM packet path. Takes the
//               stall-free beat stream from the GCM encrypt API, marks
//               first/last beats, derives byte enables from the packet length
//               field, checks the beat count against that length, and buffers
//               beats in a FIFO feeding a backpressured 128-bit output stream.
// Ports       : clk, reset           - clock / synchronous active-high reset
//               i_cp_ready, i_last   - input beat strobe / final-beat marker
//               i_cipher_text[0:127] - cipher word of the beat
//               i_bypass_text[288:0] - bypass word, [48:33] = packet length
//               o_valid, i_ready     - output handshake
//               o_data, o_keep,
//               o_first, o_last      - output beat (keep bit 15 = o_data[0:7])
//               o_overflow           - sticky, a beat was dropped on full FIFO
//               o_len_err            - one-cycle pulse on beat-count mismatch
//               o_pkt_count          - packets closed at the input (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rx_collector #(
    parameter int DEPTH   = 16,
    parameter int HDR_LEN = 14
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_cp_ready,
    input  logic           i_last,
    input  logic [0:127]   i_cipher_text,
    input  logic [288:0]   i_bypass_text,
    output logic           o_valid,
    output logic [0:127]   o_data,
    output logic [15:0]    o_keep,
    output logic           o_first,
    output logic           o_last,
    input  logic           i_ready,
    output logic           o_overflow,
    output logic           o_len_err,
    output logic [15:0]    o_pkt_count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 128 + 16 + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_BODY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        pay_q;
    logic [15:0]        exp_q;
    logic [15:0]        cnt_q;
    logic               len_err_q;
    logic [15:0]        pkt_count_q;
    logic               overflow_q;

    logic [c_ENTRY_W-1:0] mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;

    logic [15:0]          w_len;
    logic [15:0]          w_pay_new;
    logic [15:0]          w_exp_new;
    logic                 w_is_first;
    logic [15:0]          w_pay;
    logic [15:0]          w_exp;
    logic [15:0]          w_cnt;
    logic [3:0]           w_rem;
    logic [15:0]          w_keep;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_full;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_unused_bypass;

    // Only the length field of the bypass word is consumed here.
    assign w_unused_bypass = ^{i_bypass_text[288:49], i_bypass_text[32:0]};

    // ------------------------------------------------------------------
    // Length bookkeeping. A first beat uses its own length field directly so
    // that single-beat packets get correct keep and length check.
    // ------------------------------------------------------------------
    assign w_len      = i_bypass_text[48:33];
    assign w_pay_new  = (w_len < 16'(HDR_LEN)) ? 16'd0 : (w_len - 16'(HDR_LEN));
    // ceil(pay/16), with an empty payload still occupying one beat
    assign w_exp_new  = (w_pay_new == 16'd0) ? 16'd1
                                             : 16'(({1'b0, w_pay_new} + 17'd15) >> 4);
    assign w_is_first = (state_q != S_BODY);
    assign w_pay      = w_is_first ? w_pay_new : pay_q;
    assign w_exp      = w_is_first ? w_exp_new : exp_q;
    assign w_cnt      = w_is_first ? 16'd1 : (cnt_q + 16'd1);
    assign w_rem      = w_pay[3:0];
    // Partial last beat: the top rem byte lanes carry valid bytes.
    assign w_keep     = (i_last && (w_rem != 4'd0)) ? ~(16'hFFFF >> w_rem) : 16'hFFFF;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIRST: begin
                if (i_cp_ready) begin
                    state_d = i_last ? S_FIRST : S_BODY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BODY: begin
                if (i_cp_ready && i_last) begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packet tracking runs on every input beat, dropped or not, so a lost
    // last beat still closes the packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pay_q       <= 16'd0;
            exp_q       <= 16'd0;
            cnt_q       <= 16'd0;
            len_err_q   <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            len_err_q <= i_cp_ready && i_last && (w_cnt != w_exp);
            if (i_cp_ready) begin
                pay_q <= w_pay;
                exp_q <= w_exp;
                cnt_q <= w_cnt;
                if (i_last) begin
                    pkt_count_q <= pkt_count_q + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO. The head entry drives the outputs straight from storage flops,
    // giving one cycle from write to o_valid and the full DEPTH of capacity.
    // ------------------------------------------------------------------
    assign w_full  = (count_q == c_CNT_W'(DEPTH));
    assign w_rd    = (count_q != '0) && i_ready;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_wr    = i_cp_ready && (!w_full || w_rd);
    assign w_entry = {i_cipher_text, w_keep, w_is_first, i_last};

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (i_cp_ready && w_full && !w_rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign w_head      = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != '0);
    // Outputs read as zero while empty so nothing leaks from stale storage.
    assign o_data      = o_valid ? w_head[c_ENTRY_W-1:18] : 128'd0;
    assign o_keep      = o_valid ? w_head[17:2] : 16'd0;
    assign o_first     = o_valid && w_head[1];
    assign o_last      = o_valid && w_head[0];
    assign o_overflow  = overflow_q;
    assign o_len_err   = len_err_q;
    assign o_pkt_count = pkt_count_q;

endmodule
`default_nettype wire
